// File: rtl/elevator_request_latch.sv
// Button front end: sync, debounce and latch hall/cab requests; registered summaries.
// Optional CAB_CANCEL_EN: a repeat cab press on a lit button cancels it.
module elevator_request_latch #(
   parameter int N               = 5,
   parameter int FLOOR_W         = 3,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic               board_clk,
   input  logic               rst_n,
   input  logic [N:1]         request_up_button,
   input  logic [N:1]         request_down_button,
   input  logic [N:1]         input_floor_button,
   input  logic [FLOOR_W-1:0] current_floor,
   input  logic               clear_valid,
   input  logic [FLOOR_W-1:0] clear_floor,
   input  logic [1:0]         clear_dir,
   output logic [N:1]         led_up,
   output logic [N:1]         led_down,
   output logic [N:1]         led_cab,
   output logic               pending_above,
   output logic               pending_below,
   output logic               pending_here_up,
   output logic               pending_here_down,
   output logic               any_pending
);

   localparam int B     = 3 * N;
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [N:1] UP_OK = {1'b0, {(N-1){1'b1}}};
   localparam logic [N:1] DN_OK = {{(N-1){1'b1}}, 1'b0};

   logic [B-1:0]     raw;
   logic [B-1:0]     s1;
   logic [B-1:0]     s2;
   logic [B-1:0]     deb;
   logic [B-1:0]     deb_q;
   logic [B-1:0]     armed;
   logic [B-1:0]     acc;
   logic [CNT_W-1:0] cnt [B];
   logic [1:0]       vld;

   logic [N:1] acc_up;
   logic [N:1] acc_dn;
   logic [N:1] acc_cab;
   logic [N:1] up_nx;
   logic [N:1] dn_nx;
   logic [N:1] cab_nx;
   logic       above_nx;
   logic       below_nx;
   logic       here_up_nx;
   logic       here_dn_nx;
   logic       any_nx;

   assign raw = {input_floor_button, request_down_button, request_up_button};

   // A bit only arms once its synchronised level has been seen low after
   // reset, so a button held through reset must be released first.
   always_comb begin
      deb = '0;
      acc = '0;
      for (int i = 0; i < B; i++) begin
         deb[i] = (cnt[i] == CNT_MAX);
         acc[i] = deb[i] & ~deb_q[i] & armed[i];
      end
   end

   assign acc_up  = acc[N-1:0] & UP_OK;
   assign acc_dn  = acc[2*N-1:N] & DN_OK;
   assign acc_cab = acc[3*N-1:2*N];

   always_ff @(posedge board_clk) begin
      if (!rst_n) begin
         s1    <= '0;
         s2    <= '0;
         deb_q <= '0;
         armed <= '0;
         vld   <= '0;
         for (int i = 0; i < B; i++) cnt[i] <= '0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         deb_q <= deb;
         vld   <= {vld[0], 1'b1};
         armed <= armed | ({B{vld[1]}} & ~s2);
         for (int i = 0; i < B; i++) begin
            if (!s2[i])
               cnt[i] <= '0;
            else if (cnt[i] != CNT_MAX)
               cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   // Set wins over a same-cycle clear; cancel (if enabled) beats both.
   always_comb begin
      up_nx      = '0;
      dn_nx      = '0;
      cab_nx     = '0;
      above_nx   = 1'b0;
      below_nx   = 1'b0;
      here_up_nx = 1'b0;
      here_dn_nx = 1'b0;
      any_nx     = 1'b0;
      for (int f = 1; f <= N; f++) begin
         logic hit;
         logic req;
         hit = clear_valid && (clear_floor == FLOOR_W'(f));
         up_nx[f] = acc_up[f] | (led_up[f] & ~(hit & clear_dir[0]));
         dn_nx[f] = acc_dn[f] | (led_down[f] & ~(hit & clear_dir[1]));
`ifdef CAB_CANCEL_EN
         cab_nx[f] = acc_cab[f] ? ~led_cab[f] : (led_cab[f] & ~hit);
`else
         cab_nx[f] = acc_cab[f] | (led_cab[f] & ~hit);
`endif
         req = up_nx[f] | dn_nx[f] | cab_nx[f];
         any_nx = any_nx | req;
         if (FLOOR_W'(f) > current_floor) above_nx = above_nx | req;
         if (FLOOR_W'(f) < current_floor) below_nx = below_nx | req;
         if (FLOOR_W'(f) == current_floor) begin
            here_up_nx = up_nx[f] | cab_nx[f];
            here_dn_nx = dn_nx[f] | cab_nx[f];
         end
      end
   end

   always_ff @(posedge board_clk) begin
      if (!rst_n) begin
         led_up            <= '0;
         led_down          <= '0;
         led_cab           <= '0;
         pending_above     <= 1'b0;
         pending_below     <= 1'b0;
         pending_here_up   <= 1'b0;
         pending_here_down <= 1'b0;
         any_pending       <= 1'b0;
      end else begin
         led_up            <= up_nx;
         led_down          <= dn_nx;
         led_cab           <= cab_nx;
         pending_above     <= above_nx;
         pending_below     <= below_nx;
         pending_here_up   <= here_up_nx;
         pending_here_down <= here_dn_nx;
         any_pending       <= any_nx;
      end
   end

endmodule
